dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data SRAM macro (S013LLLPSP_X256Y8D8) behind the AVR core. It shares the macro between the CPU data bus (priority requester) and one external master (debug/DMA port, req/ack handshake). It also decodes the SRAM window, generates the active-low macro strobes, and stalls the CPU through `cpuwait` only when the external master has starved for `max_wait` cycles.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM macro between the AVR data bus and one external
// req/ack master; the CPU has priority until the external side has starved for max_wait cycles.
module dmem_arbiter #(
    parameter int adr_w     = 12,
    parameter int ram_depth = 11,
    parameter int ram_base  = 256,
    parameter int max_wait  = 4
) (
    input  logic                 cp2,
    input  logic                 ireset,
    input  logic [adr_w-1:0]     cpu_ramadr,
    input  logic                 cpu_ramre,
    input  logic                 cpu_ramwe,
    input  logic [7:0]           cpu_dbusout,
    output logic [7:0]           cpu_dbusin,
    output logic                 cpu_wait,
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [adr_w-1:0]     ext_adr,
    input  logic [7:0]           ext_wdata,
    output logic                 ext_ack,
    output logic [7:0]           ext_rdata,
    output logic                 ext_err,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [ram_depth-1:0] sram_a,
    output logic [7:0]           sram_d,
    input  logic [7:0]           sram_q
);

    localparam int WC_W = (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    localparam logic [adr_w:0]  WIN_LO = (adr_w+1)'(ram_base);
    localparam logic [adr_w:0]  WIN_HI = (adr_w+1)'(ram_base + (1 << ram_depth));
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(max_wait);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             ext_ack_q, ext_ack_d;
    logic             ext_err_q, ext_err_d;
    logic [7:0]       ext_rdata_q, ext_rdata_d;

    logic [adr_w:0]     cpu_adr_x, ext_adr_x;
    logic               cpu_hit, ext_hit;
    logic               cpu_acc, ext_ok, at_max, grant;
    logic [ram_depth-1:0] cpu_off, ext_off;

    // Addresses are widened by one bit so ram_base + window never wraps in the compare.
    assign cpu_adr_x = {1'b0, cpu_ramadr};
    assign ext_adr_x = {1'b0, ext_adr};
    assign cpu_hit   = (cpu_adr_x >= WIN_LO) && (cpu_adr_x < WIN_HI);
    assign ext_hit   = (ext_adr_x >= WIN_LO) && (ext_adr_x < WIN_HI);
    assign cpu_off   = ram_depth'(cpu_adr_x - WIN_LO);
    assign ext_off   = ram_depth'(ext_adr_x - WIN_LO);

    assign cpu_acc = (cpu_ramre || cpu_ramwe) && cpu_hit;
    assign ext_ok  = ext_req && ext_hit;
    assign at_max  = (wait_cnt_q == WC_MAX);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ext_err_d   = ext_err_q;
        ext_rdata_d = ext_rdata_q;
        grant       = 1'b0;
        cpu_wait    = 1'b0;
        case (state_q)
            IDLE: begin
                grant    = ext_ok && (!cpu_acc || at_max);
                cpu_wait = ext_ok && cpu_acc && at_max;
                if (grant) begin
                    state_d   = ACK;
                    ext_err_d = 1'b0;
                    if (!ext_we) begin
                        ext_rdata_d = sram_q;
                    end
                end else if (ext_req && !ext_hit) begin
                    state_d   = ACK;
                    ext_err_d = 1'b1;
                end else if (ext_ok && cpu_acc) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ACK: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (ireset) begin
            grant    = 1'b0;
            cpu_wait = 1'b0;
        end
    end

    assign ext_ack_d = (state_d == ACK);

    // The owner is the external master only in its grant cycle; otherwise the CPU.
    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = cpu_off;
        sram_d   = cpu_dbusout;
        if (grant) begin
            sram_cen = 1'b0;
            sram_wen = !ext_we;
            sram_a   = ext_off;
            sram_d   = ext_wdata;
        end else if (cpu_acc) begin
            sram_cen = 1'b0;
            sram_wen = !cpu_ramwe;
        end
        if (ireset) begin
            sram_cen = 1'b1;
            sram_wen = 1'b1;
        end
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            ext_ack_q   <= 1'b0;
            ext_err_q   <= 1'b0;
            ext_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ext_ack_q   <= ext_ack_d;
            ext_err_q   <= ext_err_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    assign ext_ack    = ext_ack_q;
    assign ext_err    = ext_err_q;
    assign ext_rdata  = ext_rdata_q;
    assign cpu_dbusin = (cpu_ramre && cpu_hit && !cpu_wait) ? sram_q : 8'h00;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: decode vector table, directed multi-cycle sequences, and a
// randomized run scored against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int ADR_W    = 12;
    localparam int RAM_D    = 11;
    localparam int BASE     = 256;
    localparam int MAX_WAIT = 4;
    localparam int WIN      = 1 << RAM_D;

    logic              cp2 = 1'b0;
    logic              ireset;
    logic [ADR_W-1:0]  cpu_ramadr;
    logic              cpu_ramre;
    logic              cpu_ramwe;
    logic [7:0]        cpu_dbusout;
    logic [7:0]        cpu_dbusin;
    logic              cpu_wait;
    logic              ext_req;
    logic              ext_we;
    logic [ADR_W-1:0]  ext_adr;
    logic [7:0]        ext_wdata;
    logic              ext_ack;
    logic [7:0]        ext_rdata;
    logic              ext_err;
    logic              sram_cen;
    logic              sram_wen;
    logic [RAM_D-1:0]  sram_a;
    logic [7:0]        sram_d;
    logic [7:0]        sram_q = 8'h00;

    logic [7:0] mem  [0:WIN-1];
    logic [7:0] gold [0:WIN-1];
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(
        .adr_w(ADR_W), .ram_depth(RAM_D), .ram_base(BASE), .max_wait(MAX_WAIT)
    ) dut (
        .cp2(cp2), .ireset(ireset),
        .cpu_ramadr(cpu_ramadr), .cpu_ramre(cpu_ramre), .cpu_ramwe(cpu_ramwe),
        .cpu_dbusout(cpu_dbusout), .cpu_dbusin(cpu_dbusin), .cpu_wait(cpu_wait),
        .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_err(ext_err),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    // Clock / reset block
    always #5 cp2 = ~cp2;

    // SRAM macro model, clocked on the falling edge
    always @(negedge cp2) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] = sram_d;
            else           sram_q = mem[sram_a];
        end
    end

    typedef struct packed {
        logic [11:0] adr;
        logic        re;
        logic        we;
        logic [7:0]  wd;
        logic        cen;
        logic        wen;
        logic        chk_a;
        logic [10:0] a;
        logic [7:0]  dbus;
    } vec_t;

    vec_t vecs [12];

    function automatic logic in_win(input logic [11:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + WIN);
    endfunction

    function automatic logic [10:0] offs(input logic [11:0] a);
        return 11'(int'(a) - BASE);
    endfunction

    function automatic logic [11:0] rand_adr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)       return 12'(BASE + $urandom_range(0, 7));
        else if (r < 7)  return 12'(BASE + WIN - 8 + $urandom_range(0, 7));
        else if (r == 7) return 12'($urandom_range(0, BASE - 1));
        else if (r == 8) return 12'(BASE + WIN + $urandom_range(0, 12'hFFF - BASE - WIN));
        else             return 12'($urandom_range(0, 12'hFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    task automatic settle();
        #6;
    endtask

    task automatic drive_cpu(input logic [11:0] a, input logic re, input logic we, input logic [7:0] d);
        cpu_ramadr  = a;
        cpu_ramre   = re;
        cpu_ramwe   = we;
        cpu_dbusout = d;
    endtask

    task automatic drive_ext(input logic req, input logic we, input logic [11:0] a, input logic [7:0] d);
        ext_req   = req;
        ext_we    = we;
        ext_adr   = a;
        ext_wdata = d;
    endtask

    task automatic preload_pattern();
        for (int i = 0; i < WIN; i++) mem[i] = 8'(i) ^ 8'h5A;
    endtask

    // Randomized run state
    logic       m_ack_now, m_err, stalled, ack_seen;
    logic [7:0] m_rdata, exp_rdata_now, exp_dbus, popped;
    int         m_def, age;
    logic       c_hit, e_hit, c_acc, e_go, e_wait, c_go, nxt_ack;

    initial begin
        vecs[0]  = '{12'h05F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};
        vecs[1]  = '{12'h100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h000, 8'h5A};
        vecs[2]  = '{12'h8FF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h7FF, 8'hA5};
        vecs[3]  = '{12'h0FF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};
        vecs[4]  = '{12'h900, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};
        vecs[5]  = '{12'h123, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h023, 8'h79};
        vecs[6]  = '{12'h8FF, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 11'h7FF, 8'h00};
        vecs[7]  = '{12'h900, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};
        vecs[8]  = '{12'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};
        vecs[9]  = '{12'h4AB, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h3AB, 8'hF1};
        vecs[10] = '{12'h8FF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h7FF, 8'h77};
        vecs[11] = '{12'hFFF, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 11'h000, 8'h00};

        // Reset: strobes forced inactive even with a pending CPU hit and ext request
        ireset = 1'b1;
        drive_cpu(12'h150, 1'b1, 1'b0, 8'h00);
        drive_ext(1'b1, 1'b0, 12'h105, 8'h00);
        preload_pattern();
        #12;
        chk("rst_ack",   ext_ack,   1'b0);
        chk("rst_err",   ext_err,   1'b0);
        chk("rst_rdata", ext_rdata, 8'h00);
        chk("rst_wait",  cpu_wait,  1'b0);
        chk("rst_cen",   sram_cen,  1'b1);
        chk("rst_wen",   sram_wen,  1'b1);
        tick();
        ireset = 1'b0;
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        settle();
        chk("idle_cen", sram_cen, 1'b1);

        // Decode vector table, external master idle
        for (int i = 0; i < 12; i++) begin
            tick();
            drive_cpu(vecs[i].adr, vecs[i].re, vecs[i].we, vecs[i].wd);
            settle();
            chk($sformatf("vec%0d_cen", i),  sram_cen,   vecs[i].cen);
            chk($sformatf("vec%0d_wen", i),  sram_wen,   vecs[i].wen);
            chk($sformatf("vec%0d_dbus", i), cpu_dbusin, vecs[i].dbus);
            chk($sformatf("vec%0d_wait", i), cpu_wait,   1'b0);
            if (vecs[i].chk_a) chk($sformatf("vec%0d_a", i), sram_a, vecs[i].a);
            if (vecs[i].we && !vecs[i].cen) chk($sformatf("vec%0d_d", i), sram_d, vecs[i].wd);
        end

        // A: CPU idle, external read of 0x105
        mem[5] = 8'hA5;
        tick();
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        drive_ext(1'b1, 1'b0, 12'h105, 8'h00);
        settle();
        chk("a_wait", cpu_wait, 1'b0);
        chk("a_cen",  sram_cen, 1'b0);
        chk("a_wen",  sram_wen, 1'b1);
        chk("a_addr", sram_a,   11'h005);
        chk("a_ack0", ext_ack,  1'b0);
        tick();
        settle();
        chk("a_ack",   ext_ack,   1'b1);
        chk("a_rdata", ext_rdata, 8'hA5);
        chk("a_err",   ext_err,   1'b0);
        chk("a_wait2", cpu_wait,  1'b0);
        tick();
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        settle();
        chk("a_ack_drop", ext_ack,   1'b0);
        chk("a_hold",     ext_rdata, 8'hA5);

        // B: CPU reads every cycle, external write 0x3C to 0x1FF preempts after max_wait
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                drive_cpu(12'h150, 1'b1, 1'b0, 8'h00);
                drive_ext(1'b1, 1'b1, 12'h1FF, 8'h3C);
            end
            settle();
            chk($sformatf("b%0d_wait", k), cpu_wait, k == 5);
            chk($sformatf("b%0d_ack", k),  ext_ack,  k == 6);
            if (k == 5) begin
                chk("b_pre_a",    sram_a,     11'h0FF);
                chk("b_pre_wen",  sram_wen,   1'b0);
                chk("b_pre_d",    sram_d,     8'h3C);
                chk("b_pre_dbus", cpu_dbusin, 8'h00);
            end else begin
                chk($sformatf("b%0d_a", k),    sram_a,     11'h050);
                chk($sformatf("b%0d_dbus", k), cpu_dbusin, 8'h0A);
            end
        end
        chk("b_err",   ext_err,   1'b0);
        chk("b_rdata", ext_rdata, 8'hA5);
        tick();
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        drive_cpu(12'h1FF, 1'b1, 1'b0, 8'h00);
        settle();
        chk("b_readback", cpu_dbusin, 8'h3C);

        // C: out-of-window external reads complete with an error and no macro access
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 2; j++) begin
            tick();
            drive_ext(1'b1, 1'b0, (j == 0) ? 12'h0FF : 12'h900, 8'h00);
            settle();
            chk($sformatf("c%0d_cen0", j), sram_cen, 1'b1);
            chk($sformatf("c%0d_ack0", j), ext_ack,  1'b0);
            tick();
            settle();
            chk($sformatf("c%0d_ack", j),   ext_ack,   1'b1);
            chk($sformatf("c%0d_err", j),   ext_err,   1'b1);
            chk($sformatf("c%0d_cen1", j),  sram_cen,  1'b1);
            chk($sformatf("c%0d_rdata", j), ext_rdata, 8'hA5);
            tick();
            drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
            settle();
            chk($sformatf("c%0d_drop", j), ext_ack, 1'b0);
        end

        // D: request held across the ack under CPU traffic; deferral count restarts
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                drive_cpu(12'h150, 1'b1, 1'b0, 8'h00);
                drive_ext(1'b1, 1'b0, 12'h110, 8'h00);
            end
            settle();
            chk($sformatf("d%0d_wait", k), cpu_wait, (k == 5) || (k == 11));
            chk($sformatf("d%0d_ack", k),  ext_ack,  (k == 6) || (k == 12));
            if (ext_ack) chk($sformatf("d%0d_rdata", k), ext_rdata, 8'h4A);
        end
        tick();
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        settle();
        chk("d_drop", ext_ack, 1'b0);

        // D2: request held with CPU idle alternates grant and ack
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) drive_ext(1'b1, 1'b0, 12'h105, 8'h00);
            settle();
            chk($sformatf("d2_%0d_cen", k), sram_cen, (k % 2) == 0);
            chk($sformatf("d2_%0d_ack", k), ext_ack,  (k % 2) == 0);
        end
        chk("d2_rdata", ext_rdata, 8'hA5);
        tick();
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        settle();

        // E: reset during the ACK state
        tick();
        drive_ext(1'b1, 1'b0, 12'h105, 8'h00);
        settle();
        chk("e_ack0", ext_ack, 1'b0);
        tick();
        settle();
        chk("e_ack1", ext_ack, 1'b1);
        #1;
        ireset = 1'b1;
        drive_cpu(12'h150, 1'b1, 1'b0, 8'h00);
        #1;
        chk("e_rst_ack",   ext_ack,   1'b0);
        chk("e_rst_rdata", ext_rdata, 8'h00);
        chk("e_rst_err",   ext_err,   1'b0);
        chk("e_rst_cen",   sram_cen,  1'b1);
        chk("e_rst_wen",   sram_wen,  1'b1);
        chk("e_rst_wait",  cpu_wait,  1'b0);
        tick();
        settle();
        chk("e_rst_hold_ack", ext_ack,  1'b0);
        chk("e_rst_hold_cen", sram_cen, 1'b1);
        tick();
        ireset = 1'b0;
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        settle();
        chk("e_rel_ack",   ext_ack,   1'b0);
        chk("e_rel_rdata", ext_rdata, 8'h00);
        tick();
        drive_ext(1'b1, 1'b0, 12'h105, 8'h00);
        settle();
        chk("e_new_cen", sram_cen, 1'b0);
        chk("e_new_ack", ext_ack,  1'b0);
        tick();
        settle();
        chk("e_new_ack1",  ext_ack,   1'b1);
        chk("e_new_rdata", ext_rdata, 8'hA5);

        // Randomized run against the transaction-level model
        tick();
        ireset = 1'b1;
        drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
        drive_cpu(12'h000, 1'b0, 1'b0, 8'h00);
        tick();
        ireset = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem[i]  = v;
            gold[i] = v;
        end
        m_ack_now = 1'b0;
        m_err     = 1'b0;
        m_rdata   = 8'h00;
        m_def     = 0;
        stalled   = 1'b0;
        ack_seen  = 1'b0;
        age       = 0;
        exp_q.delete();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!stalled) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      drive_cpu(rand_adr(), 1'b1, 1'b0, 8'h00);
                else if (r < 7) drive_cpu(rand_adr(), 1'b0, 1'b1, 8'($urandom));
                else            drive_cpu(rand_adr(), 1'b0, 1'b0, 8'h00);
            end
            if (!ext_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive_ext(1'b1, 1'($urandom_range(0, 1)), rand_adr(), 8'($urandom));
                    age = 0;
                end
            end else if (ack_seen) begin
                if ($urandom_range(0, 1) == 1) begin
                    drive_ext(1'b1, 1'($urandom_range(0, 1)), rand_adr(), 8'($urandom));
                    age = 0;
                end else begin
                    drive_ext(1'b0, 1'b0, 12'h000, 8'h00);
                end
            end
            if (ext_req) age++;

            exp_rdata_now = m_rdata;
            c_hit   = in_win(cpu_ramadr);
            e_hit   = in_win(ext_adr);
            c_acc   = (cpu_ramre || cpu_ramwe) && c_hit;
            e_go    = 1'b0;
            e_wait  = 1'b0;
            nxt_ack = 1'b0;
            if (m_ack_now) begin
                m_def = 0;
            end else if (ext_req) begin
                if (!e_hit) begin
                    nxt_ack = 1'b1;
                    m_err   = 1'b1;
                    exp_q.push_back(m_rdata);
                end else if (!c_acc || m_def == MAX_WAIT) begin
                    e_go    = 1'b1;
                    e_wait  = c_acc;
                    nxt_ack = 1'b1;
                    m_err   = 1'b0;
                    if (!ext_we) m_rdata = gold[offs(ext_adr)];
                    exp_q.push_back(m_rdata);
                end else begin
                    m_def++;
                end
            end
            c_go     = c_acc && !e_wait;
            exp_dbus = (cpu_ramre && c_hit && !e_wait) ? gold[offs(cpu_ramadr)] : 8'h00;

            settle();
            chk("r_wait",  cpu_wait,   e_wait);
            chk("r_ack",   ext_ack,    m_ack_now);
            chk("r_cen",   sram_cen,   !(e_go || c_go));
            chk("r_dbus",  cpu_dbusin, exp_dbus);
            chk("r_rdata", ext_rdata,  exp_rdata_now);
            if (ext_ack) begin
                if (exp_q.size() == 0) begin
                    chk("r_ack_unexpected", ext_ack, 1'b0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("r_ack_data", ext_rdata, popped);
                    chk("r_err", ext_err, m_err);
                    chk("r_latency_ok", age <= MAX_WAIT + 2, 1'b1);
                end
            end else if (ext_req && age > MAX_WAIT + 2) begin
                chk("r_ack_timeout", ext_ack, 1'b1);
            end

            if (e_go && ext_we) gold[offs(ext_adr)] = ext_wdata;
            if (c_go && cpu_ramwe) gold[offs(cpu_ramadr)] = cpu_dbusout;
            ack_seen  = m_ack_now || (ext_req && age > MAX_WAIT + 2);
            m_ack_now = nxt_ack;
            stalled   = e_wait;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
